instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage directly upstream of the control unit.
- Keeps the PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched word in an IF/ID slot plus a one-entry skid buffer.
- Presents the split fields (op, rs, rt, rd, shamt, funct) to decode and the control unit.
- Supports decode back-pressure and PC redirect with flush.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- PC_STEP, 4, PC increment per fetched word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  fetch enable; 0 stops issuing new requests.
- imem_req  output  1  request to instruction memory.
- imem_addr  output  ADDR_W  fetch address; valid while imem_req=1.
- imem_ack  input  1  one-cycle response strobe.
- imem_data  input  32  instruction word; valid when imem_ack=1.
- id_ready  input  1  decode accepts the slot this cycle.
- redirect  input  1  branch/jump redirect and flush.
- redirect_pc  input  ADDR_W  new fetch address.
- id_valid  output  1  IF/ID slot holds a valid instruction.
- id_pc  output  ADDR_W  address of the slot instruction.
- id_instr  output  32  slot instruction word.
- op  output  6  id_instr[31:26], to the control unit.
- rs  output  5  id_instr[25:21].
- rt  output  5  id_instr[20:16].
- rd  output  5  id_instr[15:11].
- shamt  output  5  id_instr[10:6].
- funct  output  6  id_instr[5:0].

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_pc=0, id_instr=0, skid empty, drop flag=0.
- Field outputs: purely combinational slices of id_instr. op=0 after reset, so consumers must qualify everything with id_valid.
- Memory protocol:
  - Exactly one outstanding request at a time.
  - imem_req and imem_addr are held stable until imem_ack. An ack with imem_req=0 is ignored.
  - Minimum latency is ack in the same cycle as req. The first slot load is then visible one cycle after req.
- Slot transfer: occurs when id_valid & id_ready. "Slot free" means !id_valid | id_ready.
- FSM states: IDLE, FETCH, SKID.
- IDLE:
  - imem_req=0.
  - en=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with slot free:
    - id_instr<=imem_data, id_pc<=pc, id_valid<=1, pc<=pc+PC_STEP.
    - Next state FETCH if en, else IDLE.
  - On imem_ack with slot full and !id_ready:
    - skid<=imem_data, skid_pc<=pc, pc<=pc+PC_STEP.
    - Next state SKID.
  - If en drops while waiting, the request completes first, then IDLE.
  - With id_ready=1 continuously and same-cycle ack, throughput is 1 instruction/cycle.
- SKID:
  - imem_req=0.
  - On id_ready: slot<=skid, id_valid stays 1. Next state FETCH if en, else IDLE.
- No ack and slot consumed: id_valid<=0.
- Redirect (highest priority):
  - id_valid<=0, skid emptied.
  - pc<=redirect_pc with bits[1:0] forced to 00.
  - Next state FETCH if en, else IDLE.
  - If a request is outstanding and not acked in the redirect cycle: set drop flag. Keep req/addr stable until its ack, discard that word, clear the flag, then request the new pc.
  - An ack arriving in the same cycle as redirect is discarded.
- PC arithmetic: modulo 2^ADDR_W; wraps from max-aligned to 0 silently.
- Reset mid-transaction: the transaction is abandoned. Instruction memory shares rst, so no stale ack may follow.

Decomposition:
- Shared package:
  - Opcode constants (OP_RTYPE=6'b000000, OP_READ=6'b000001).
  - Instruction field bit positions.
  - FSM state encoding.
  - INSTR_W=32.
- Sub-module if_id_buffer: slot + skid registers with load/advance/flush. FSM and PC stay in the top module.

Test Plan:
- Reset then en=1, id_ready=1, memory acks same cycle with words 0x00000020, 0x04000001 -> imem_addr 0,4,8…; id_valid=1 with op=0x00 then op=0x01; id_pc 0 then 4.
- id_ready=0 for 3 cycles while a second word is acked -> word captured in skid, imem_req=0; after id_ready=1, second word appears the cycle after first is consumed; no word lost or duplicated.
- Redirect to 0x103 while a request to 0x8 is outstanding, ack arrives 2 cycles later -> that word is dropped; next request has imem_addr=0x100; id_valid=0 until the 0x100 word returns.
- Redirect and imem_ack in the same cycle -> acked word discarded; id_valid=0 next cycle; pc=redirect target.
- RESET_PC=0xFFFFFFFC, two fetches -> imem_addr sequence 0xFFFFFFFC, 0x00000000.
- Assert rst mid-wait (memory latency 3) -> all outputs at reset values immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: word width, opcode
// constants, instruction field positions and the fetch FSM encoding.
package instruction_fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_READ  = 6'b000001;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SKID  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID slot plus a one-entry skid register. Flush beats load, load beats
// skid capture, and a consumed slot refills from the skid when it holds a word.
module if_id_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic               skid_load_i,
  input  logic               ready_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] data_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = data_i;
    end else if (skid_load_i) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = pc_i;
      skid_instr_d = data_i;
    end else if (valid_q && ready_i) begin
      // Slot consumed: refill from skid or go empty
      if (skid_valid_q) begin
        pc_d         = skid_pc_q;
        instr_d      = skid_instr_q;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC and the single-outstanding imem req/ack handshake,
// feeds the IF/ID buffer and handles redirects, including late-ack dropping.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [5:0]         op,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct
);

  fetch_state_e      state_q, state_d, resume;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              drop_q, drop_d;
  logic              ack, slot_free;
  logic              load, skid_load, flush;

  assign ack       = imem_ack & req_q;
  assign slot_free = ~id_valid | id_ready;
  assign pc_inc    = pc_q + ADDR_W'(PC_STEP);
  assign resume    = en ? FETCH : IDLE;

  // Next-state, PC and buffer control; redirect overrides everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    load      = 1'b0;
    skid_load = 1'b0;
    flush     = 1'b0;
    if (redirect) begin
      flush   = 1'b1;
      pc_d    = redirect_pc & ~ADDR_W'(3);
      drop_d  = req_q & ~imem_ack;
      state_d = drop_d ? FETCH : resume;
    end else if (drop_q) begin
      if (ack) begin
        drop_d  = 1'b0;
        state_d = resume;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = FETCH;
        end
        FETCH: begin
          if (ack) begin
            pc_d = pc_inc;
            if (slot_free) begin
              load    = 1'b1;
              state_d = resume;
            end else begin
              skid_load = 1'b1;
              state_d   = SKID;
            end
          end
        end
        SKID: begin
          if (id_ready) state_d = resume;
        end
        default: state_d = IDLE;
      endcase
    end
    req_d  = (state_d == FETCH);
    // A request being dropped keeps its original address until acked
    addr_d = drop_d ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
    end
  end

  if_id_buffer #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .load_i      (load),
    .skid_load_i (skid_load),
    .ready_i     (id_ready),
    .pc_i        (pc_q),
    .data_i      (imem_data),
    .valid_o     (id_valid),
    .pc_o        (id_pc),
    .instr_o     (id_instr)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  assign op    = id_instr[OP_LSB +: OP_W];
  assign rs    = id_instr[RS_LSB +: REG_W];
  assign rt    = id_instr[RT_LSB +: REG_W];
  assign rd    = id_instr[RD_LSB +: REG_W];
  assign shamt = id_instr[SHAMT_LSB +: SHAMT_W];
  assign funct = id_instr[FUNCT_LSB +: FUNCT_W];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed scenarios followed by
// randomized latency/back-pressure/redirect traffic against a program-order model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, en, id_ready, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack, id_valid;
  logic [31:0] imem_addr, imem_data, id_pc, id_instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;

  logic        imem_req_w, imem_ack_w, id_valid_w;
  logic [31:0] imem_addr_w, imem_data_w, id_pc_w, id_instr_w;
  logic [5:0]  op_w, funct_w;
  logic [4:0]  rs_w, rt_w, rd_w, shamt_w;
  logic        one = 1'b1, zero = 1'b0;
  logic [31:0] zero32 = 32'd0;

  int   total = 0, bad = 0, n_xfer = 0;
  int   wcnt, lat_r, fixed_lat, need;
  logic rand_lat, stray;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0000_0020;
    if (a == 32'd4) return 32'h0400_0001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  instruction_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct)
  );

  instruction_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_data(imem_data_w),
    .id_ready(one), .redirect(zero), .redirect_pc(zero32),
    .id_valid(id_valid_w), .id_pc(id_pc_w), .id_instr(id_instr_w),
    .op(op_w), .rs(rs_w), .rt(rt_w), .rd(rd_w), .shamt(shamt_w), .funct(funct_w)
  );

  // Memory responders: main one has programmable latency and stray acks
  assign need        = rand_lat ? lat_r : fixed_lat;
  assign imem_ack    = (imem_req && (wcnt >= need)) || (stray && !imem_req);
  assign imem_data   = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  assign imem_ack_w  = imem_req_w;
  assign imem_data_w = mem_word(imem_addr_w);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= 0;
      lat_r <= 0;
    end else if (imem_req && !imem_ack) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      if (imem_req) lat_r <= int'($urandom_range(0, 3));
    end
  end

  // Reference model state: program-order delivery and fetch-address sequence
  logic [31:0] exp_q[$];
  logic [31:0] model_pc, fetch_exp, prev_addr, e;
  logic        dropping, prev_hold, prev_redir, ack_m;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_pc   = 32'd0;
        fetch_exp  = 32'd0;
        dropping   = 1'b0;
        prev_hold  = 1'b0;
        prev_redir = 1'b0;
      end else begin
        ack_m = imem_req && imem_ack;
        if (prev_redir) chk("flush_valid", 64'(id_valid), 64'd0);
        if (prev_hold) chk("req_hold", 64'({imem_req, imem_addr}), 64'({1'b1, prev_addr}));
        else if (imem_req) chk("req_addr", 64'(imem_addr), 64'(fetch_exp));
        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(model_pc);
            model_pc += 32'd4;
          end
          e = exp_q.pop_front();
          chk("xfer_pc", 64'(id_pc), 64'(e));
          chk("xfer_instr", 64'(id_instr), 64'(mem_word(e)));
          chk("xfer_fields", 64'({op, rs, rt, rd, shamt, funct}), 64'(mem_word(e)));
          n_xfer++;
        end
        if (ack_m) begin
          if (dropping) dropping = 1'b0;
          else if (!redirect) fetch_exp += 32'd4;
        end
        if (redirect) begin
          exp_q.delete();
          model_pc  = redirect_pc & ~32'd3;
          fetch_exp = model_pc;
          dropping  = imem_req && !ack_m;
        end
        prev_hold  = imem_req && !ack_m;
        prev_addr  = imem_addr;
        prev_redir = redirect;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    rand_lat = 1'b0; stray = 1'b0; fixed_lat = 0;
    tick(); tick();
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_pc", 64'(id_pc), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'd0);
    chk("rst_addr_w", 64'(imem_addr_w), 64'hFFFF_FFFC);

    // Streaming with same-cycle ack
    rst = 1'b0; en = 1'b1; id_ready = 1'b1;
    tick(); smp();
    chk("t1_req", 64'(imem_req), 64'd1);
    chk("t1_addr0", 64'(imem_addr), 64'd0);
    chk("wrap_addr0", 64'(imem_addr_w), 64'hFFFF_FFFC);
    tick(); smp();
    chk("t1_valid", 64'(id_valid), 64'd1);
    chk("t1_op0", 64'(op), 64'h00);
    chk("t1_pc0", 64'(id_pc), 64'd0);
    chk("t1_addr4", 64'(imem_addr), 64'd4);
    chk("wrap_addr1", 64'(imem_addr_w), 64'd0);
    chk("wrap_idpc", 64'(id_pc_w), 64'hFFFF_FFFC);
    tick(); smp();
    chk("t1_op1", 64'(op), 64'h01);
    chk("t1_pc4", 64'(id_pc), 64'd4);

    // Back-pressure into the skid register
    tick(); id_ready = 1'b0;
    smp();
    tick(); smp();
    chk("t2_skid_req", 64'(imem_req), 64'd0);
    chk("t2_hold_pc", 64'(id_pc), 64'd8);
    tick();
    tick(); id_ready = 1'b1;
    smp();
    chk("t2_still_pc", 64'(id_pc), 64'd8);
    tick(); smp();
    chk("t2_adv_pc", 64'(id_pc), 64'd12);
    chk("t2_resume", 64'({imem_req, imem_addr}), 64'({1'b1, 32'd16}));

    // Redirect while the request to 0x8 is outstanding
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
    tick(); tick(); tick();
    fixed_lat = 2; redirect = 1'b1; redirect_pc = 32'h103;
    tick(); redirect = 1'b0;
    smp();
    chk("t3_drop_valid", 64'(id_valid), 64'd0);
    chk("t3_drop_hold", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h8}));
    tick(); smp();
    chk("t3_drop_hold2", 64'(imem_addr), 64'h8);
    tick(); fixed_lat = 0;
    smp();
    chk("t3_new_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h100}));
    chk("t3_still_empty", 64'(id_valid), 64'd0);
    tick(); smp();
    chk("t3_first", 64'({id_valid, id_pc}), 64'({1'b1, 32'h100}));

    // Redirect coinciding with an ack
    tick(); redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect = 1'b0;
    smp();
    chk("t4_valid", 64'(id_valid), 64'd0);
    chk("t4_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h200}));
    tick(); smp();
    chk("t4_first", 64'({id_valid, id_pc}), 64'({1'b1, 32'h200}));

    // Asynchronous reset during a slow access
    tick(); fixed_lat = 3;
    tick(); smp();
    chk("t6_waiting", 64'(imem_req), 64'd1);
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("t6_req", 64'(imem_req), 64'd0);
    chk("t6_addr", 64'(imem_addr), 64'd0);
    chk("t6_valid", 64'(id_valid), 64'd0);
    chk("t6_idpc", 64'(id_pc), 64'd0);
    chk("t6_instr", 64'(id_instr), 64'd0);
    tick(); rst = 1'b0; fixed_lat = 0;
    tick(); smp();
    chk("t6_restart", 64'({imem_req, imem_addr}), 64'({1'b1, 32'd0}));

    // Randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      en          = ($urandom_range(0, 7) != 0);
      id_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      stray       = ($urandom_range(0, 5) == 0);
    end
    tick(); redirect = 1'b0; stray = 1'b0; id_ready = 1'b1; en = 1'b1;
    repeat (10) tick();
    chk("activity", 64'(n_xfer > 500), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
